// File: rtl/i2c_reg_master_pkg.sv
// Shared types and constants for the I2C register master.
package i2c_reg_master_pkg;

    // Bus-level FSM states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        TX_BYTE,
        RX_ACK,
        RSTART,
        RX_BYTE,
        TX_NACK,
        STOP
    } state_t;

    // Quarter phases inside one bit slot.
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // R/W bit appended to the 7-bit device address.
    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit prescaler: one-cycle tick every CLK_DIV cycles, frozen while hold is high.
module i2c_tick_gen #(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick_c = (cnt == CNT_MAX) && !hold;

    // Free-running divider, restarted while the master is idle.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2c_reg_master.sv
// Single-master I2C engine: one 8-bit register write or read per request.
// Optional feature: define I2C_CLOCK_STRETCH_EN to let slaves stretch SCL.
module i2c_reg_master
    import i2c_reg_master_pkg::*;
#(
    parameter int unsigned CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] chip_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] value,
    input  logic       enable,
    input  logic       is_read,
    inout  wire        sda,
    inout  wire        scl,
    output logic [7:0] data,
    output logic       done,
    output logic       i2c_ack_error
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] phase;
    logic [2:0] bit_cnt;
    logic [1:0] byte_idx;
    logic [6:0] addr_q;
    logic [7:0] reg_q;
    logic [7:0] value_q;
    logic       read_q;
    logic [7:0] rx_shift;
    logic       sda_oe;
    logic       scl_oe;
    logic       sda_oe_d;
    logic       scl_oe_d;
    logic [7:0] tx_byte;
    logic       tick_c;
    logic       hold_c;
    logic       slot_end_c;

    assign slot_end_c = tick_c && (phase == Q3);

`ifdef I2C_CLOCK_STRETCH_EN
    logic [1:0] scl_sync;

    // Two-flop synchronizer on the SCL pin for stretch detection.
    always_ff @(posedge clk) begin
        if (!reset) begin
            scl_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl};
        end
    end

    assign hold_c = (state != IDLE) && (phase == Q2) && !scl_sync[1];
`else
    assign hold_c = 1'b0;
`endif

    i2c_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (state == IDLE),
        .hold   (hold_c),
        .tick_c (tick_c)
    );

    // State register plus the bit/byte datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            phase         <= Q0;
            bit_cnt       <= 3'd7;
            byte_idx      <= 2'd0;
            addr_q        <= 7'd0;
            reg_q         <= 8'd0;
            value_q       <= 8'd0;
            read_q        <= 1'b0;
            rx_shift      <= 8'd0;
            sda_oe        <= 1'b0;
            scl_oe        <= 1'b0;
            done          <= 1'b1;
            data          <= 8'd0;
            i2c_ack_error <= 1'b0;
        end else begin
            state  <= state_nxt;
            sda_oe <= sda_oe_d;
            scl_oe <= scl_oe_d;
            if (state == IDLE) begin
                phase <= Q0;
                if (enable) begin
                    addr_q        <= chip_addr;
                    reg_q         <= reg_addr;
                    value_q       <= value;
                    read_q        <= is_read;
                    bit_cnt       <= 3'd7;
                    byte_idx      <= 2'd0;
                    i2c_ack_error <= 1'b0;
                    done          <= 1'b0;
                end
            end else if (tick_c) begin
                phase <= phase + 2'd1;
                if (phase == Q3) begin
                    case (state)
                        TX_BYTE: bit_cnt <= bit_cnt - 3'd1;
                        RX_BYTE: begin
                            bit_cnt  <= bit_cnt - 3'd1;
                            rx_shift <= {rx_shift[6:0], sda};
                        end
                        RX_ACK: begin
                            if (sda) begin
                                i2c_ack_error <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end
                        STOP: begin
                            done <= 1'b1;
                            if (read_q && !i2c_ack_error) begin
                                data <= rx_shift;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    // Slot-level sequencing; every transition happens at the end of Q3.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = START;
            START:   if (slot_end_c) state_nxt = TX_BYTE;
            TX_BYTE: if (slot_end_c && bit_cnt == 3'd0) state_nxt = RX_ACK;
            RX_ACK: begin
                if (slot_end_c) begin
                    if (sda) begin
                        state_nxt = STOP;
                    end else if (byte_idx == 2'd2) begin
                        state_nxt = read_q ? RX_BYTE : STOP;
                    end else if (byte_idx == 2'd1 && read_q) begin
                        state_nxt = RSTART;
                    end else begin
                        state_nxt = TX_BYTE;
                    end
                end
            end
            RSTART:  if (slot_end_c) state_nxt = TX_BYTE;
            RX_BYTE: if (slot_end_c && bit_cnt == 3'd0) state_nxt = TX_NACK;
            TX_NACK: if (slot_end_c) state_nxt = STOP;
            STOP:    if (slot_end_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Line drive per state and quarter; SCL is low in Q0/Q1 of every clocked slot.
    always_comb begin
        sda_oe_d = 1'b0;
        scl_oe_d = 1'b0;
        case (byte_idx)
            2'd0:    tx_byte = {addr_q, RW_WRITE};
            2'd1:    tx_byte = reg_q;
            default: tx_byte = read_q ? {addr_q, RW_READ} : value_q;
        endcase
        case (state)
            START: sda_oe_d = (phase == Q2) || (phase == Q3);
            TX_BYTE: begin
                scl_oe_d = (phase == Q0) || (phase == Q1);
                sda_oe_d = !tx_byte[bit_cnt];
            end
            RX_ACK, RX_BYTE, TX_NACK: scl_oe_d = (phase == Q0) || (phase == Q1);
            RSTART: begin
                scl_oe_d = (phase == Q0) || (phase == Q1);
                sda_oe_d = (phase == Q3);
            end
            STOP: begin
                scl_oe_d = (phase == Q0) || (phase == Q1);
                sda_oe_d = (phase != Q3);
            end
            default: ;
        endcase
    end

    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign scl = scl_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_reg_master.sv
// Randomized bench for i2c_reg_master with a behavioural I2C slave and transaction model.
`timescale 1ns/1ps
module tb_i2c_reg_master;

    localparam int unsigned CLK_DIV = 4;
    localparam int BUS_S = 256;
    localparam int BUS_P = 257;
`ifdef I2C_CLOCK_STRETCH_EN
    localparam int SLACK = 4;
`else
    localparam int SLACK = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       is_read = 1'b0;
    logic [6:0] chip_addr = 7'd0;
    logic [7:0] reg_addr = 8'd0;
    logic [7:0] value = 8'd0;
    logic [7:0] data;
    logic       done;
    logic       i2c_ack_error;
    wire        sda;
    wire        scl;

    logic       slv_sda_low = 1'b0;
    logic       slv_scl_low = 1'b0;
    logic       slv_present = 1'b1;
    logic [6:0] slv_addr = 7'h39;
    logic [7:0] slv_rd_data = 8'h00;
    logic       stretch_req = 1'b0;

    pullup (sda);
    pullup (scl);
    assign sda = slv_sda_low ? 1'b0 : 1'bz;
    assign scl = slv_scl_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_reg_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk           (clk),
        .reset         (reset),
        .chip_addr     (chip_addr),
        .reg_addr      (reg_addr),
        .value         (value),
        .enable        (enable),
        .is_read       (is_read),
        .sda           (sda),
        .scl           (scl),
        .data          (data),
        .done          (done),
        .i2c_ack_error (i2c_ack_error)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_data = 8'h00;
    logic       exp_err = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus monitor and slave: sampled mid-cycle, logs bytes and START/STOP events.
    int         bus_log[$];
    int         master_ack_log[$];
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         bitn = 0;
    int         nbytes = 0;
    int         stretch_left = 0;
    logic [7:0] shreg = 8'h00;
    logic       in_ack = 1'b0;
    logic       slave_tx = 1'b0;
    logic       addressed = 1'b0;

    always @(negedge clk) begin
        logic s_scl;
        logic s_sda;
        s_scl = scl;
        s_sda = sda;
        if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) slv_scl_low = 1'b0;
        end
        if (prev_scl && s_scl && prev_sda && !s_sda) begin
            bus_log.push_back(BUS_S);
            bitn = 0; nbytes = 0; in_ack = 1'b0; slave_tx = 1'b0; slv_sda_low = 1'b0;
        end else if (prev_scl && s_scl && !prev_sda && s_sda) begin
            bus_log.push_back(BUS_P);
            bitn = 0; nbytes = 0; in_ack = 1'b0; slave_tx = 1'b0; addressed = 1'b0; slv_sda_low = 1'b0;
        end else if (!prev_scl && s_scl) begin
            if (!in_ack) begin
                shreg = {shreg[6:0], s_sda};
                bitn++;
            end else if (slave_tx) begin
                master_ack_log.push_back(int'(s_sda));
            end
        end else if (prev_scl && !s_scl) begin
            if (!in_ack && bitn == 8) begin
                bus_log.push_back(int'(shreg));
                in_ack = 1'b1;
                if (slave_tx) begin
                    slv_sda_low = 1'b0;
                end else begin
                    if (nbytes == 0) addressed = slv_present && (shreg[7:1] == slv_addr);
                    slv_sda_low = addressed;
                end
            end else if (in_ack) begin
                in_ack = 1'b0;
                bitn = 0;
                slv_sda_low = 1'b0;
                if (slave_tx) begin
                    slave_tx = 1'b0;
                end else if (nbytes == 0 && addressed && shreg[0]) begin
                    slave_tx = 1'b1;
                    slv_sda_low = !slv_rd_data[7];
                end
                if (stretch_req && nbytes == 1 && addressed) begin
                    slv_scl_low = 1'b1;
                    stretch_left = 300;
                    stretch_req = 1'b0;
                end
                nbytes++;
            end else if (slave_tx && bitn >= 1 && bitn <= 7) begin
                slv_sda_low = !slv_rd_data[3'(7 - bitn)];
            end
        end
        prev_scl = s_scl;
        prev_sda = s_sda;
    end

    // One full request; expected bus bytes, latency, data and error come from the protocol rules.
    task automatic run_txn(input string tag, input logic rd, input logic [6:0] ca,
                           input logic [7:0] ra, input logic [7:0] va, input logic present,
                           input logic [7:0] rdd, input int extra);
        int   exp_q[$];
        int   slots;
        int   n;
        int   lo;
        int   hi;
        logic ack;
        ack = present && (ca == slv_addr);
        exp_q = {BUS_S, int'({ca, 1'b0})};
        if (!ack) begin
            exp_q.push_back(BUS_P);
            slots = 11;
        end else if (!rd) begin
            exp_q.push_back(int'(ra));
            exp_q.push_back(int'(va));
            exp_q.push_back(BUS_P);
            slots = 29;
        end else begin
            exp_q.push_back(int'(ra));
            exp_q.push_back(BUS_S);
            exp_q.push_back(int'({ca, 1'b1}));
            exp_q.push_back(int'(rdd));
            exp_q.push_back(BUS_P);
            slots = 39;
        end
        if (ack && rd) exp_data = rdd;
        exp_err = !ack;

        bus_log.delete();
        master_ack_log.delete();
        slv_present = present;
        slv_rd_data = rdd;
        @(negedge clk);
        chip_addr = ca; reg_addr = ra; value = va; is_read = rd; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check({tag, "/done_fall"}, int'(done), 0);
        n = 0;
        while (done !== 1'b1 && n < slots * 4 * CLK_DIV + extra + 1000) begin
            @(negedge clk);
            n++;
        end
        lo = (extra == 0) ? slots * 4 * CLK_DIV - 1 : slots * 4 * CLK_DIV + extra - 20;
        hi = slots * 4 * CLK_DIV + 1 + SLACK * slots + extra + ((extra == 0) ? 0 : 10);
        check({tag, "/latency"}, (n >= lo && n <= hi) ? slots * 4 * CLK_DIV : n, slots * 4 * CLK_DIV);
        check({tag, "/data"}, int'(data), int'(exp_data));
        check({tag, "/ack_err"}, int'(i2c_ack_error), int'(exp_err));
        check({tag, "/bus_len"}, bus_log.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < bus_log.size(); i++) begin
            check($sformatf("%s/bus[%0d]", tag, i), bus_log[i], exp_q[i]);
        end
        if (ack && rd) begin
            check({tag, "/nack_cnt"}, master_ack_log.size(), 1);
            if (master_ack_log.size() > 0) check({tag, "/master_nack"}, master_ack_log[0], 1);
        end
        repeat (3) @(negedge clk);
        check({tag, "/idle_sda"}, int'(sda), 1);
        check({tag, "/idle_scl"}, int'(scl), 1);
    endtask

    initial begin
        int n;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset/done", int'(done), 1);
        check("reset/ack_err", int'(i2c_ack_error), 0);
        check("reset/data", int'(data), 0);
        check("reset/sda", int'(sda), 1);
        check("reset/scl", int'(scl), 1);
        bus_log.delete();
        repeat (50) @(negedge clk);
        check("idle/no_activity", bus_log.size(), 0);
        check("idle/done", int'(done), 1);

        run_txn("wr_basic", 1'b0, 7'h39, 8'h41, 8'h10, 1'b1, 8'h00, 0);
        run_txn("rd_basic", 1'b1, 7'h39, 8'h9E, 8'h00, 1'b1, 8'h10, 0);
        run_txn("no_slave", 1'b0, 7'h39, 8'h41, 8'h10, 1'b0, 8'h00, 0);
        run_txn("rd_noslave", 1'b1, 7'h39, 8'h22, 8'h00, 1'b0, 8'hA5, 0);
        run_txn("wr_recover", 1'b0, 7'h39, 8'h42, 8'h5A, 1'b1, 8'h00, 0);

        for (int t = 0; t < 12; t++) begin
            logic [6:0] ca;
            ca = (($urandom % 4) == 0) ? 7'($urandom) : 7'h39;
            run_txn($sformatf("rand%0d", t), 1'($urandom), ca, 8'($urandom), 8'($urandom),
                    1'(($urandom % 5) != 0), 8'($urandom), 0);
        end

`ifdef I2C_CLOCK_STRETCH_EN
        stretch_req = 1'b1;
        run_txn("stretch_wr", 1'b0, 7'h39, 8'h41, 8'h33, 1'b1, 8'h00, 300);
        stretch_req = 1'b0;
`endif

        // Reset in the middle of the register byte.
        bus_log.delete();
        slv_present = 1'b1;
        @(negedge clk);
        chip_addr = 7'h39; reg_addr = 8'h41; value = 8'h77; is_read = 1'b0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (n < 14 * 4 * CLK_DIV + 6) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        check("midreset/sda", int'(sda), 1);
        check("midreset/scl", int'(scl), 1);
        check("midreset/done", int'(done), 1);
        reset = 1'b1;
        exp_data = 8'h00;
        exp_err = 1'b0;
        check("midreset/data", int'(data), 0);
        repeat (5) @(negedge clk);
        run_txn("after_reset", 1'b0, 7'h39, 8'h41, 8'h10, 1'b1, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
